axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

- AXI slave endpoint with a word-addressed on-chip SRAM behind it.
- Connects directly to the AW/W/B/AR/R ports of the `Master` block and services its SINGLE, INCR, WRAP4 and INCR4 bursts.
- Write and read paths are independent FSMs and may be active at the same time.
- Used as the default memory target in the bus testbench and in small subsystems.

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of `AXI_DATA_BITS`-wide words; must be a power of two.

Ports. All widths come from the shared AXI define file:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESETn  in  1  reset. One clock; reset is asynchronous and active-low.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  `AXI_ID_BITS`/`AXI_ADDR_BITS`/`AXI_LEN_BITS`/`AXI_SIZE_BITS`/2  write address.
- AWVALID  in  1; AWREADY  out  1.
- WDATA  in  `AXI_DATA_BITS`; WSTRB  in  `AXI_STRB_BITS`; WLAST  in  1; WVALID  in  1; WREADY  out  1.
- BID  out  `AXI_ID_BITS`; BRESP  out  2; BVALID  out  1; BREADY  in  1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  same widths as AW*; ARVALID  in  1; ARREADY  out  1.
- RID  out  `AXI_ID_BITS`; RDATA  out  `AXI_DATA_BITS`; RRESP  out  2; RLAST  out  1; RVALID  out  1; RREADY  in  1.

## Operation
- Burst encoding:
  - 00 SINGLE: 1 beat; LEN ignored.
  - 01 INCR: LEN+1 beats.
  - 10 WRAP4: 4 beats; wraps on a 4×(1<<SIZE) byte boundary.
  - 11 INCR4: 4 beats, incrementing.
  - LEN is ignored for WRAP4 and INCR4.
- Address step is 1<<SIZE. SIZE above log2(`AXI_STRB_BITS`) is clamped to that value.
- Word index is the address shifted right by log2(`AXI_STRB_BITS`).
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: AWREADY=1. An AW handshake latches ID, start address, beat count and burst type.
  - W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB (WSTRB=0 writes nothing), then advances the address.
  - The internal beat count ends the burst, not WLAST. If WLAST does not match the final beat, BRESP=SLVERR (10); data is still written.
  - W_RESP: BVALID=1, BID=latched AWID, BRESP=OKAY (00) unless an error was flagged. BVALID and BID/BRESP hold until BREADY.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: ARREADY=1. An AR handshake latches ID, address and beat count.
  - R_DATA: RVALID=1, RID=latched ARID, RRESP=OKAY.
  - RDATA is combinational from the array at the registered beat address.
  - RLAST=1 when the beat counter equals the final beat. Beats advance only on an R handshake.
- Memory contents are not reset.

## Timing
- All outputs are registered, except RDATA and RLAST, which are combinational from registered state.
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BID, BRESP, RID, RRESP, RDATA = 0.
- AWREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Write timing:
  - AW handshake at edge n: AWREADY=0 and WREADY=1 from n+1.
  - Last W handshake at edge m: WREADY=0 and BVALID=1 from m+1.
  - B handshake at edge k: BVALID=0 and AWREADY=1 from k+1.
  - Minimum single-beat write occupancy is 3 cycles.
- Read timing:
  - AR handshake at edge n: ARREADY=0 and RVALID=1 with beat-0 data from n+1.
  - Beats stream back-to-back while RREADY=1.
  - Last R handshake at edge m: RVALID=0 and ARREADY=1 from m+1.
- Simultaneous write and read of the same word in the same cycle: the read returns the old data; the new data is visible from the next cycle.
- WRAP4 example (SIZE=2, start 0x18): beat addresses 0x18, 0x1C, 0x10, 0x14.
- Reset mid-burst: the burst is abandoned immediately (asynchronous) and all outputs go to their reset values. No response is issued for the abandoned transaction.
- An INCR burst crossing the top of the array follows the out-of-range rule below.

## Configuration
- SLAVE_RANGE_ERR_EN defined:
  - A beat whose word index is ≥ DEPTH_WORDS is an error.
  - For writes, the beat is suppressed and BRESP=SLVERR.
  - For reads, RRESP=SLVERR and RDATA=0 for that beat only.
- SLAVE_RANGE_ERR_EN undefined:
  - Word index is the address modulo DEPTH_WORDS (upper bits discarded).
  - Responses are always OKAY unless a WLAST mismatch occurs.

## Test plan
- Reset, then SINGLE write ID=3, addr 0x40, data 0xDEADBEEF, WSTRB 1111, BREADY=1 → BVALID 2 cycles after AW handshake, BID=3, BRESP=00. A SINGLE read of 0x40 then returns 0xDEADBEEF with RLAST=1 and RID equal to ARID.
- INCR LEN=3 write of 0x11,0x22,0x33,0x44 at 0x100, then INCR4 read of 0x100 with RREADY=1 → 4 consecutive RVALID cycles returning 0x11..0x44, RLAST only on beat 4.
- WRAP4 SIZE=2 read at 0x18 after writing words 0x10..0x1C → data returned in order 0x18, 0x1C, 0x10, 0x14.
- Partial strobe: write 0xAABBCCDD with WSTRB 0101 over existing 0x00000000 → readback 0x00BB00DD. A WLAST deasserted on the final beat → BRESP=10.
- RREADY and BREADY toggled 0/1 every cycle during bursts → RVALID/BVALID, data and IDs hold stable while not accepted; no beat is lost or duplicated.
- ARESETn pulled low mid-INCR write (beat 2 of 4) → all valid/ready outputs drop immediately to 0. After release, AWREADY=1 on the next edge and a new burst completes normally.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI AW/W/B/AR/R channel bundle shared by the master and axi_sram_slave.
// Channel widths come from the AXI_* defines; fallbacks are supplied when the define file is absent.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

interface axi_sram_slave_if;
    logic [`AXI_ID_BITS-1:0]   AWID;
    logic [`AXI_ADDR_BITS-1:0] AWADDR;
    logic [`AXI_LEN_BITS-1:0]  AWLEN;
    logic [`AXI_SIZE_BITS-1:0] AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;

    logic [`AXI_DATA_BITS-1:0] WDATA;
    logic [`AXI_STRB_BITS-1:0] WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;

    logic [`AXI_ID_BITS-1:0]   BID;
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;

    logic [`AXI_ID_BITS-1:0]   ARID;
    logic [`AXI_ADDR_BITS-1:0] ARADDR;
    logic [`AXI_LEN_BITS-1:0]  ARLEN;
    logic [`AXI_SIZE_BITS-1:0] ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;

    logic [`AXI_ID_BITS-1:0]   RID;
    logic [`AXI_DATA_BITS-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI slave with a word-addressed SRAM; independent write and read FSMs.
// Define SLAVE_RANGE_ERR_EN to flag beats beyond DEPTH_WORDS with SLVERR instead of aliasing.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_sram_slave #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    axi_sram_slave_if.slave   s_axi
);
    localparam int ID_W       = `AXI_ID_BITS;
    localparam int ADDR_W     = `AXI_ADDR_BITS;
    localparam int LEN_W      = `AXI_LEN_BITS;
    localparam int SIZE_W     = `AXI_SIZE_BITS;
    localparam int DATA_W     = `AXI_DATA_BITS;
    localparam int STRB_W     = `AXI_STRB_BITS;
    localparam int WORD_SHIFT = $clog2(STRB_W);
    localparam int IDX_W      = $clog2(DEPTH_WORDS);
`ifdef SLAVE_RANGE_ERR_EN
    localparam bit RANGE_ERR_EN = 1'b1;
`else
    localparam bit RANGE_ERR_EN = 1'b0;
`endif

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_SINGLE = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP4  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    function automatic logic [SIZE_W-1:0] clamp_size(input logic [SIZE_W-1:0] s);
        if (s > SIZE_W'(WORD_SHIFT)) return SIZE_W'(WORD_SHIFT);
        return s;
    endfunction

    // WRAP4 keeps the bits above the 4-beat span and wraps the offset inside it.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [SIZE_W-1:0] s,
                                                    input logic [1:0] b);
        logic [ADDR_W-1:0] step;
        logic [ADDR_W-1:0] mask;
        step = ADDR_W'(1) << s;
        mask = (step << 2) - ADDR_W'(1);
        if (b == BURST_WRAP4) return (a & ~mask) | ((a + step) & mask);
        return a + step;
    endfunction

    function automatic logic [LEN_W-1:0] last_beat(input logic [LEN_W-1:0] len,
                                                   input logic [1:0] b);
        case (b)
            BURST_SINGLE: return '0;
            BURST_INCR:   return len;
            default:      return LEN_W'(3);
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> WORD_SHIFT);
    endfunction

    function automatic logic range_err(input logic [ADDR_W-1:0] a);
        return RANGE_ERR_EN && ((a >> WORD_SHIFT) >= ADDR_W'(DEPTH_WORDS));
    endfunction

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [SIZE_W-1:0] w_size_q, w_size_d;
    logic [1:0]        w_burst_q, w_burst_d;
    logic [LEN_W-1:0]  w_last_q, w_last_d;
    logic [LEN_W-1:0]  w_beat_q, w_beat_d;
    logic              w_err_q, w_err_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              mem_we;

    r_state_t          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [SIZE_W-1:0] r_size_q, r_size_d;
    logic [1:0]        r_burst_q, r_burst_d;
    logic [LEN_W-1:0]  r_last_q, r_last_d;
    logic [LEN_W-1:0]  r_beat_q, r_beat_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [ID_W-1:0]   rid_q, rid_d;

    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_last_d  = w_last_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.AWVALID && awready_q) begin
                    bid_d     = s_axi.AWID;
                    w_addr_d  = s_axi.AWADDR;
                    w_size_d  = clamp_size(s_axi.AWSIZE);
                    w_burst_d = s_axi.AWBURST;
                    w_last_d  = last_beat(s_axi.AWLEN, s_axi.AWBURST);
                    w_beat_d  = '0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi.WVALID && wready_q) begin
                    mem_we = !range_err(w_addr_q);
                    if (range_err(w_addr_q)) w_err_d = 1'b1;
                    // The beat counter ends the burst; WLAST only contributes to the response.
                    if (w_beat_q == w_last_q) begin
                        if (!s_axi.WLAST) w_err_d = 1'b1;
                        bresp_d   = w_err_d ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        if (s_axi.WLAST) w_err_d = 1'b1;
                        w_beat_d = w_beat_q + LEN_W'(1);
                        w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
                    end
                end
            end
            W_RESP: begin
                if (s_axi.BREADY && bvalid_q) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_size_q  <= '0;
            w_burst_q <= '0;
            w_last_q  <= '0;
            w_beat_q  <= '0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_last_q  <= w_last_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
        end
    end

    // Array contents are deliberately left out of reset.
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.WSTRB[b]) mem[word_idx(w_addr_q)][8*b +: 8] <= s_axi.WDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_last_d  = r_last_q;
        r_beat_d  = r_beat_q;
        rid_d     = rid_q;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.ARVALID && arready_q) begin
                    rid_d     = s_axi.ARID;
                    r_addr_d  = s_axi.ARADDR;
                    r_size_d  = clamp_size(s_axi.ARSIZE);
                    r_burst_d = s_axi.ARBURST;
                    r_last_d  = last_beat(s_axi.ARLEN, s_axi.ARBURST);
                    r_beat_d  = '0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s_axi.RREADY && rvalid_q) begin
                    if (r_beat_q == r_last_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_d = r_beat_q + LEN_W'(1);
                        r_addr_d = next_addr(r_addr_q, r_size_q, r_burst_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_DATA);
        rresp_d   = (rvalid_d && range_err(r_addr_d)) ? RESP_SLVERR : RESP_OKAY;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_size_q  <= '0;
            r_burst_q <= '0;
            r_last_q  <= '0;
            r_beat_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rid_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_last_q  <= r_last_d;
            r_beat_q  <= r_beat_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.BID     = bid_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RRESP   = rresp_q;
    assign s_axi.RID     = rid_q;
    // Read data is taken straight from the array, so a same-cycle write is seen one cycle later.
    assign s_axi.RDATA   = (r_state_q == R_DATA && !range_err(r_addr_q)) ? mem[word_idx(r_addr_q)] : '0;
    assign s_axi.RLAST   = (r_state_q == R_DATA) && (r_beat_q == r_last_q);
endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: vector table of single write/readback pairs,
// plus hand-written burst, wrap, strobe, WLAST, back-pressure and reset sequences.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module tb_axi_sram_slave;
    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    axi_sram_slave_if bus ();
    axi_sram_slave #(.DEPTH_WORDS(1024)) dut (.ACLK(ACLK), .ARESETn(ARESETn), .s_axi(bus));

    typedef struct { logic [31:0] data; logic last; logic [3:0] id; logic [1:0] resp; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct {
        logic [31:0] waddr; logic [31:0] wdata; logic [3:0] wstrb; logic [1:0] wresp;
        logic [31:0] raddr; logic [31:0] rdata; logic [1:0] rresp;
    } vec_t;

    int nerr = 0;
    int nchk = 0;
    rexp_t rq[$];
    bexp_t bq[$];
    vec_t vt[7];
    logic [31:0] mdl [0:1023];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic fail_to(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: actual=timeout required=handshake", nm);
    endtask

    function automatic int nb(input logic [3:0] len, input logic [1:0] b);
        if (b == 2'b00) return 1;
        if (b == 2'b01) return int'(len) + 1;
        return 4;
    endfunction

    // Byte address of beat i, worked out independently of the design's stepping logic.
    function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [1:0] b, input int i);
        logic [31:0] step, span, base;
        step = (sz > 3'd2) ? 32'd4 : (32'd1 << sz);
        span = step * 4;
        base = a - (a % span);
        case (b)
            2'b00:   return a;
            2'b10:   return base + (((a - base) + step * 32'(i)) % span);
            default: return a + step * 32'(i);
        endcase
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'h3FF);
    endfunction

    function automatic bit oor(input logic [31:0] a);
`ifdef SLAVE_RANGE_ERR_EN
        return (a >> 2) >= 32'd1024;
`else
        return (a[31:12] != 20'h0) && 1'b0;
`endif
    endfunction

    task automatic push_model(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                              input logic [2:0] sz, input logic [1:0] b);
        int n;
        rexp_t e;
        logic [31:0] ba;
        n = nb(len, b);
        for (int i = 0; i < n; i++) begin
            ba = baddr(a, sz, b, i);
            e.data = oor(ba) ? 32'h0 : mdl[widx(ba)];
            e.last = (i == n - 1);
            e.id   = id;
            e.resp = oor(ba) ? 2'b10 : 2'b00;
            rq.push_back(e);
        end
    endtask

    task automatic push_c(input logic [31:0] d, input logic last, input logic [3:0] id);
        rexp_t e;
        e.data = d; e.last = last; e.id = id; e.resp = 2'b00;
        rq.push_back(e);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                            input logic [2:0] sz, input logic [1:0] b, input bit tog,
                            input bit bad_last, input logic [1:0] exp_resp);
        int n, cyc;
        bit hs, v;
        bexp_t be;
        logic [31:0] ba;
        logic [3:0] bid;
        logic [1:0] br;
        n = nb(len, b);
        be.id = id; be.resp = exp_resp;
        bq.push_back(be);
        bus.AWID = id; bus.AWADDR = a; bus.AWLEN = len; bus.AWSIZE = sz; bus.AWBURST = b;
        bus.AWVALID = 1'b1;
        cyc = 0;
        do begin
            hs = bus.AWREADY;
            @(posedge ACLK); #1;
            cyc++;
        end while (!hs && cyc < 20);
        bus.AWVALID = 1'b0;
        if (!hs) begin
            fail_to("aw_handshake");
            bq.delete();
            return;
        end
        chk("aw_awready_low", bus.AWREADY, 0);
        chk("aw_wready_high", bus.WREADY, 1);
        chk("aw_bvalid_low", bus.BVALID, 0);
        for (int i = 0; i < n; i++) begin
            bus.WDATA = wd[i]; bus.WSTRB = ws[i];
            bus.WLAST = (i == n - 1) ^ bad_last;
            bus.WVALID = 1'b1;
            cyc = 0;
            do begin
                hs = bus.WREADY;
                @(posedge ACLK); #1;
                cyc++;
            end while (!hs && cyc < 20);
            if (!hs) begin
                fail_to("w_handshake");
                bus.WVALID = 1'b0;
                bq.delete();
                return;
            end
            ba = baddr(a, sz, b, i);
            if (!oor(ba))
                for (int k = 0; k < 4; k++)
                    if (ws[i][k]) mdl[widx(ba)][8*k +: 8] = wd[i][8*k +: 8];
        end
        bus.WVALID = 1'b0;
        bus.WLAST = 1'b0;
        chk("w_done_bvalid", bus.BVALID, 1);
        chk("w_done_wready", bus.WREADY, 0);
        cyc = 0;
        hs = 0;
        while (!hs && cyc < 40) begin
            bus.BREADY = tog ? cyc[0] : 1'b1;
            v = bus.BVALID;
            hs = v && bus.BREADY;
            bid = bus.BID;
            br = bus.BRESP;
            @(posedge ACLK); #1;
            cyc++;
            if (hs) begin
                be = bq.pop_front();
                chk("b_id", bid, be.id);
                chk("b_resp", br, be.resp);
                chk("b_done_bvalid", bus.BVALID, 0);
                chk("b_done_awready", bus.AWREADY, 1);
            end else if (v) begin
                chk("b_hold_bvalid", bus.BVALID, 1);
                chk("b_hold_bid", bus.BID, bq[0].id);
                chk("b_hold_bresp", bus.BRESP, bq[0].resp);
            end
        end
        bus.BREADY = 1'b0;
        if (!hs) begin
            fail_to("b_handshake");
            bq.delete();
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len,
                           input logic [2:0] sz, input logic [1:0] b, input bit tog);
        int cyc;
        bit hs, v;
        rexp_t e;
        logic [31:0] rd;
        logic rl;
        logic [3:0] ri;
        logic [1:0] rr;
        bus.ARID = id; bus.ARADDR = a; bus.ARLEN = len; bus.ARSIZE = sz; bus.ARBURST = b;
        bus.ARVALID = 1'b1;
        cyc = 0;
        do begin
            hs = bus.ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end while (!hs && cyc < 20);
        bus.ARVALID = 1'b0;
        if (!hs) begin
            fail_to("ar_handshake");
            rq.delete();
            return;
        end
        chk("ar_arready_low", bus.ARREADY, 0);
        chk("ar_rvalid_high", bus.RVALID, 1);
        cyc = 0;
        while (rq.size() > 0 && cyc < 100) begin
            bus.RREADY = tog ? cyc[0] : 1'b1;
            v = bus.RVALID;
            hs = v && bus.RREADY;
            rd = bus.RDATA; rl = bus.RLAST; ri = bus.RID; rr = bus.RRESP;
            if (!v) begin
                chk("r_valid_during_burst", v, 1);
                rq.delete();
            end
            @(posedge ACLK); #1;
            cyc++;
            if (hs) begin
                e = rq.pop_front();
                chk("r_data", rd, e.data);
                chk("r_last", rl, e.last);
                chk("r_id", ri, e.id);
                chk("r_resp", rr, e.resp);
            end else if (v) begin
                chk("r_hold_valid", bus.RVALID, 1);
                chk("r_hold_data", bus.RDATA, rq[0].data);
                chk("r_hold_id", bus.RID, rq[0].id);
            end
        end
        bus.RREADY = 1'b0;
        if (rq.size() > 0) begin
            fail_to("r_beats");
            rq.delete();
        end
        chk("r_done_rvalid", bus.RVALID, 0);
        chk("r_done_arready", bus.ARREADY, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, bus.AWREADY, 0);
        chk({tag, "_wready"}, bus.WREADY, 0);
        chk({tag, "_bvalid"}, bus.BVALID, 0);
        chk({tag, "_arready"}, bus.ARREADY, 0);
        chk({tag, "_rvalid"}, bus.RVALID, 0);
        chk({tag, "_rlast"}, bus.RLAST, 0);
        chk({tag, "_rdata"}, bus.RDATA, 0);
        chk({tag, "_bid"}, bus.BID, 0);
        chk({tag, "_bresp"}, bus.BRESP, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        bit hs;
        bus.AWVALID = 0; bus.WVALID = 0; bus.BREADY = 0; bus.ARVALID = 0; bus.RREADY = 0;
        bus.AWID = 0; bus.AWADDR = 0; bus.AWLEN = 0; bus.AWSIZE = 0; bus.AWBURST = 0;
        bus.WDATA = 0; bus.WSTRB = 0; bus.WLAST = 0;
        bus.ARID = 0; bus.ARADDR = 0; bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;

        vt[0] = '{32'h200, 32'h00000000, 4'hF, 2'b00, 32'h200, 32'h00000000, 2'b00};
        vt[1] = '{32'h200, 32'hAABBCCDD, 4'h5, 2'b00, 32'h200, 32'h00BB00DD, 2'b00};
        vt[2] = '{32'h204, 32'h12345678, 4'hF, 2'b00, 32'h204, 32'h12345678, 2'b00};
        vt[3] = '{32'h204, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h204, 32'h12345678, 2'b00};
        vt[4] = '{32'h204, 32'h9ABCDEF0, 4'hA, 2'b00, 32'h204, 32'h9A34DE78, 2'b00};
        vt[5] = '{32'hFFC, 32'hCAFEF00D, 4'hF, 2'b00, 32'hFFC, 32'hCAFEF00D, 2'b00};
`ifdef SLAVE_RANGE_ERR_EN
        vt[6] = '{32'h1008, 32'h5A5A5A5A, 4'hF, 2'b10, 32'h1008, 32'h00000000, 2'b10};
`else
        vt[6] = '{32'h1008, 32'h5A5A5A5A, 4'hF, 2'b00, 32'h008, 32'h5A5A5A5A, 2'b00};
`endif

        // Reset values and first-edge ready
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outputs("rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        chk("rst_rel_awready_pre", bus.AWREADY, 0);
        @(posedge ACLK); #1;
        chk("rst_rel_awready", bus.AWREADY, 1);
        chk("rst_rel_arready", bus.ARREADY, 1);

        // SINGLE write then read
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'd3, 32'h40, 4'd0, 3'd2, 2'b00, 1'b0, 1'b0, 2'b00);
        push_c(32'hDEADBEEF, 1'b1, 4'd5);
        do_read(4'd5, 32'h40, 4'd0, 3'd2, 2'b00, 1'b0);

        // INCR LEN=3 write, INCR4 read (ARLEN ignored)
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(4'd1, 32'h100, 4'd3, 3'd2, 2'b01, 1'b0, 1'b0, 2'b00);
        push_c(32'h11, 1'b0, 4'd2); push_c(32'h22, 1'b0, 4'd2);
        push_c(32'h33, 1'b0, 4'd2); push_c(32'h44, 1'b1, 4'd2);
        do_read(4'd2, 32'h100, 4'd7, 3'd2, 2'b11, 1'b0);

        // Vector table: single write followed by readback
        for (int i = 0; i < 7; i++) begin
            rexp_t e;
            wd[0] = vt[i].wdata; ws[0] = vt[i].wstrb;
            do_write(4'(i), vt[i].waddr, 4'd0, 3'd2, 2'b00, 1'b0, 1'b0, vt[i].wresp);
            e.data = vt[i].rdata; e.last = 1'b1; e.id = 4'(i + 8); e.resp = vt[i].rresp;
            rq.push_back(e);
            do_read(4'(i + 8), vt[i].raddr, 4'd0, 3'd2, 2'b00, 1'b0);
        end

        // WRAP4 read at 0x18
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        do_write(4'd4, 32'h10, 4'd0, 3'd2, 2'b11, 1'b0, 1'b0, 2'b00);
        push_c(32'hA2, 1'b0, 4'd7); push_c(32'hA3, 1'b0, 4'd7);
        push_c(32'hA0, 1'b0, 4'd7); push_c(32'hA1, 1'b1, 4'd7);
        do_read(4'd7, 32'h18, 4'd0, 3'd2, 2'b10, 1'b0);

        // SIZE above the bus width is clamped to a 4-byte step
        wd[0] = 32'hD0; wd[1] = 32'hD1;
        do_write(4'd6, 32'h700, 4'd1, 3'd3, 2'b01, 1'b0, 1'b0, 2'b00);
        push_c(32'hD0, 1'b0, 4'd6); push_c(32'hD1, 1'b1, 4'd6);
        do_read(4'd6, 32'h700, 4'd1, 3'd2, 2'b01, 1'b0);

        // WLAST on the wrong beats: SLVERR, data still written
        wd[0] = 32'h1; wd[1] = 32'h2;
        do_write(4'd9, 32'h500, 4'd1, 3'd2, 2'b01, 1'b0, 1'b1, 2'b10);
        push_model(4'd9, 32'h500, 4'd1, 3'd2, 2'b01);
        do_read(4'd9, 32'h500, 4'd1, 3'd2, 2'b01, 1'b0);

        // BREADY / RREADY toggling every cycle
        wd[0] = 32'hB0; wd[1] = 32'hB1; wd[2] = 32'hB2; wd[3] = 32'hB3;
        do_write(4'd10, 32'h600, 4'd3, 3'd2, 2'b01, 1'b1, 1'b0, 2'b00);
        push_model(4'd11, 32'h600, 4'd3, 3'd2, 2'b01);
        do_read(4'd11, 32'h600, 4'd3, 3'd2, 2'b01, 1'b1);

        // Reset asserted during beat 2 of an INCR write
        bus.AWID = 4'd1; bus.AWADDR = 32'h300; bus.AWLEN = 4'd3; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01;
        bus.AWVALID = 1'b1;
        cyc = 0;
        do begin hs = bus.AWREADY; @(posedge ACLK); #1; cyc++; end while (!hs && cyc < 20);
        bus.AWVALID = 1'b0;
        if (!hs) fail_to("mid_rst_aw");
        bus.WDATA = 32'h777; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b1;
        cyc = 0;
        do begin hs = bus.WREADY; @(posedge ACLK); #1; cyc++; end while (!hs && cyc < 20);
        if (!hs) fail_to("mid_rst_w");
        mdl[widx(32'h300)] = 32'h777;
        bus.WDATA = 32'h888;
        #2;
        ARESETn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        bus.WVALID = 1'b0;
        @(posedge ACLK); #1;
        chk("midrst_held_awready", bus.AWREADY, 0);
        #2;
        ARESETn = 1'b1;
        chk("midrst_rel_awready_pre", bus.AWREADY, 0);
        @(posedge ACLK); #1;
        chk("midrst_rel_awready", bus.AWREADY, 1);
        chk("midrst_rel_bvalid", bus.BVALID, 0);
        wd[0] = 32'hC0; wd[1] = 32'hC1; wd[2] = 32'hC2; wd[3] = 32'hC3;
        do_write(4'd12, 32'h300, 4'd0, 3'd2, 2'b11, 1'b0, 1'b0, 2'b00);
        push_model(4'd13, 32'h300, 4'd3, 3'd2, 2'b01);
        do_read(4'd13, 32'h300, 4'd3, 3'd2, 2'b01, 1'b0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
